mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arb_wait_cnt.sv | 16 +
 rtl/mem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, func3 width codes and defaults for mem_arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LATENCY_DEF = 2;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_arb_wait_cnt.sv
// mem_arb_wait_cnt: loadable down-counter timing a memory access, with zero flag
module mem_arb_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] init,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requests onto a single-port memory bus, alternating priority.
// Define MEM_ARB_ALIGN_CHECK_EN to reject misaligned accesses with err instead of touching memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  state_t state;
  logic [31:0] lat_addr, lat_wdata, g_addr;
  logic [2:0] lat_f3, g_f3;
  logic lat_we, last_d, grant_d, grant_if, grant, bad, cnt_zero;
  mem_arb_wait_cnt u_cnt (
    .clk(clk),
    .rst(rst),
    .load(grant && !bad),
    .dec(state != IDLE),
    .init(LAT_M1),
    .zero(cnt_zero)
  );
  // data wins a tie unless it won the previous grant
  always_comb begin
    grant_d = d_req && (!if_req || !last_d);
    grant_if = if_req && !grant_d;
    grant = state == IDLE && (grant_d || grant_if);
    g_addr = grant_d ? d_addr : if_addr;
    g_f3 = grant_d ? d_func3 : F3_W;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    bad = misaligned(g_f3, g_addr[1:0]);
`else
    bad = 1'b0;
`endif
  end
  assign busy = state != IDLE;
  assign mem_addr = lat_addr;
  assign mem_func3 = lat_f3;
  assign mem_wdata = lat_wdata;
  assign mem_memread = state == IF_ACC || (state == D_ACC && !lat_we);
  assign mem_memwrite = state == D_ACC && lat_we && cnt_zero;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last_d <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_f3 <= '0;
      lat_we <= 1'b0;
      if_done <= 1'b0;
      d_done <= 1'b0;
      err <= 1'b0;
      if_inst <= '0;
      d_rdata <= '0;
    end else begin
      if_done <= 1'b0;
      d_done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          last_d <= grant_d;
          lat_addr <= g_addr;
          lat_f3 <= g_f3;
          lat_we <= grant_d && d_we;
          lat_wdata <= d_wdata;
          if (bad) begin
            if_done <= grant_if;
            d_done <= grant_d;
            err <= 1'b1;
          end else state <= grant_d ? D_ACC : IF_ACC;
        end
        default: if (cnt_zero) begin
          state <= IDLE;
          if (state == IF_ACC) begin
            if_done <= 1'b1;
            if_inst <= mem_rdata;
          end else begin
            d_done <= 1'b1;
            if (!lat_we) d_rdata <= mem_rdata;
          end
        end
      endcase
    end
  end
endmodule
